// File: rtl/seg7_char_rotator.sv
// ============================================================================
//  Module   : seg7_char_rotator
//  Brief    : Multi-digit seven-segment character display with a writable
//             character buffer and prescaled left/right rotation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_char_rotator #(
    parameter  int NUM_DIGITS = 4,
    parameter  int TICK_DIV   = 50000000,
    localparam int AW         = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    RUN,
    input  logic                    DIR,
    input  logic                    WR,
    input  logic [AW-1:0]           ADDR,
    input  logic [2:0]              CHAR,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [AW-1:0]           POS,
    output logic                    STEP
);

    localparam int             c_CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(TICK_DIV - 1);
    localparam logic [AW-1:0]  c_POS_MAX = AW'(NUM_DIGITS - 1);

    logic [c_CW-1:0]           r_cnt;
    logic [AW-1:0]             r_pos;
    logic                      r_step;
    logic [2:0]                r_buf [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0]   r_hex;

    logic                      w_tick;
    logic                      w_addr_ok;
    logic [AW-1:0]             w_pos_next;
    logic [7*NUM_DIGITS-1:0]   w_hex;

    // Active-low gfedcba patterns for the character codes.
    function automatic logic [6:0] f_seg(input logic [2:0] code);
        case (code)
            3'd0:    return 7'b0100001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1111001;
            3'd4:    return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Buffer entry shown on digit k: (k + NUM_DIGITS - pos) mod NUM_DIGITS.
    function automatic logic [AW-1:0] f_idx(input int k, input logic [AW-1:0] pos);
        int s;
        s = k + NUM_DIGITS - int'(pos);
        if (s >= NUM_DIGITS) begin
            s = s - NUM_DIGITS;
        end
        return AW'(s);
    endfunction

    generate
        if ((NUM_DIGITS & (NUM_DIGITS - 1)) == 0) begin : g_addr_pow2
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_range
            assign w_addr_ok = ({1'b0, ADDR} < (AW+1)'(NUM_DIGITS));
        end
    endgenerate

    assign w_tick = RUN && (r_cnt == c_CNT_MAX);

    always_comb begin
        w_pos_next = r_pos;
        if (DIR) begin
            w_pos_next = (r_pos == '0) ? c_POS_MAX : r_pos - AW'(1);
        end else begin
            w_pos_next = (r_pos == c_POS_MAX) ? '0 : r_pos + AW'(1);
        end
    end

    always_comb begin
        w_hex = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_hex[7*k +: 7] = f_seg(r_buf[f_idx(k, r_pos)]);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_pos  <= '0;
            r_step <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buf[i]        <= 3'(i % 4);
                r_hex[7*i +: 7] <= f_seg(3'(i % 4));
            end
        end else begin
            r_hex <= w_hex;
            if (WR && w_addr_ok) begin
                r_buf[ADDR] <= CHAR;
            end
            if (w_tick) begin
                r_cnt  <= '0;
                r_pos  <= w_pos_next;
                r_step <= 1'b1;
            end else begin
                r_step <= 1'b0;
                if (RUN) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
    end

    assign HEX  = r_hex;
    assign POS  = r_pos;
    assign STEP = r_step;

endmodule

`default_nettype wire

// File: tb/tb_seg7_char_rotator.sv
// ============================================================================
//  Module   : tb_seg7_char_rotator
//  Brief    : Directed scoreboard bench for seg7_char_rotator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_char_rotator;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int N5 = 5;

    localparam logic [27:0] c_HEX_RST  = 28'b1111111_1111001_0000110_0100001;
    localparam logic [34:0] c_HEX5_RST = 35'b0100001_1111111_1111001_0000110_0100001;
    localparam logic [34:0] c_HEX5_WR  = 35'b0111111_1111111_1111001_0000110_0100001;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        dir;
    logic        wr;
    logic [1:0]  addr;
    logic [2:0]  chr;
    logic [27:0] hex;
    logic [1:0]  pos;
    logic        step;

    logic        run5;
    logic        dir5;
    logic        wr5;
    logic [2:0]  addr5;
    logic [2:0]  chr5;
    logic [34:0] hex5;
    logic [2:0]  pos5;
    logic        step5;

    exp_t        sb[$];
    int          checks;
    int          errors;

    int          mcnt;
    int          mpos;
    int          mstep;
    logic [2:0]  mbuf [N];
    logic [6:0]  seg_tbl [8];

    seg7_char_rotator #(.NUM_DIGITS(N), .TICK_DIV(TD)) u_dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .RUN      (run),
        .DIR      (dir),
        .WR       (wr),
        .ADDR     (addr),
        .CHAR     (chr),
        .HEX      (hex),
        .POS      (pos),
        .STEP     (step)
    );

    seg7_char_rotator #(.NUM_DIGITS(N5), .TICK_DIV(2)) u_dut5 (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .RUN      (run5),
        .DIR      (dir5),
        .WR       (wr5),
        .ADDR     (addr5),
        .CHAR     (chr5),
        .HEX      (hex5),
        .POS      (pos5),
        .STEP     (step5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic m_reset();
        mcnt  = 0;
        mpos  = 0;
        mstep = 0;
        for (int i = 0; i < N; i++) mbuf[i] = 3'(i % 4);
    endtask

    function automatic logic [27:0] m_hex();
        logic [27:0] v;
        for (int k = 0; k < N; k++) v[7*k +: 7] = seg_tbl[mbuf[(k - mpos + N) % N]];
        return v;
    endfunction

    // One clock edge: predict from pre-edge model state, then compare after the edge.
    task automatic cyc();
        logic [27:0] h;
        h = m_hex();
        if (run) begin
            if (mcnt == TD - 1) begin
                mcnt  = 0;
                mpos  = dir ? (mpos + N - 1) % N : (mpos + 1) % N;
                mstep = 1;
            end else begin
                mcnt  = mcnt + 1;
                mstep = 0;
            end
        end else begin
            mstep = 0;
        end
        if (wr) mbuf[addr] = chr;
        push("hex", 64'(h));
        push("pos", 64'(mpos));
        push("step", 64'(mstep));
        @(posedge clk);
        #1;
        chk(64'(hex));
        chk(64'(pos));
        chk(64'(step));
    endtask

    task automatic chk_reset();
        push("rst_hex", 64'(c_HEX_RST));
        push("rst_pos", 64'd0);
        push("rst_step", 64'd0);
        chk(64'(hex));
        chk(64'(pos));
        chk(64'(step));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 chk_reset();
        #1 rst = 1'b0;
        m_reset();
    endtask

    initial begin
        seg_tbl = '{7'b0100001, 7'b0000110, 7'b1111001, 7'b1111111,
                    7'b0111111, 7'b1111111, 7'b1111111, 7'b1111111};
        checks = 0;
        errors = 0;
        rst   = 1'b1;
        run   = 1'b0;
        dir   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        chr   = '0;
        run5  = 1'b0;
        dir5  = 1'b0;
        wr5   = 1'b0;
        addr5 = '0;
        chr5  = '0;
        m_reset();

        repeat (2) @(posedge clk);
        #1;
        chk_reset();

        // Left rotation from reset release
        rst = 1'b0;
        run = 1'b1;
        repeat (4) cyc();
        cyc();
        push("left_hex_lo", 64'({7'b0100001, 7'b1111111}));
        chk(64'(hex[13:0]));
        repeat (12) cyc();

        // Right rotation
        pulse_reset();
        dir = 1'b1;
        repeat (4) cyc();
        cyc();
        push("right_hex0", 64'(7'b0000110));
        chk(64'(hex[6:0]));
        push("right_hex3", 64'(7'b0100001));
        chk(64'(hex[27:21]));
        repeat (4) cyc();

        // Freeze and resume
        pulse_reset();
        dir = 1'b0;
        repeat (2) cyc();
        run = 1'b0;
        repeat (10) cyc();
        run = 1'b1;
        repeat (2) cyc();
        push("resume_step", 64'd1);
        chk(64'(step));

        // Write coinciding with a tick
        pulse_reset();
        repeat (3) cyc();
        wr   = 1'b1;
        addr = 2'd0;
        chr  = 3'd4;
        cyc();
        wr = 1'b0;
        cyc();
        push("wr_hex1", 64'(7'b0111111));
        chk(64'(hex[13:7]));
        push("wr_pos", 64'd1);
        chk(64'(pos));
        wr   = 1'b1;
        addr = 2'd3;
        chr  = 3'd2;
        cyc();
        wr  = 1'b0;
        dir = 1'b1;
        repeat (6) cyc();

        // Async reset mid-rotation restores rewritten entries
        pulse_reset();
        dir = 1'b0;
        repeat (6) cyc();

        // Out-of-range addresses on a 5-digit instance
        wr5   = 1'b1;
        addr5 = 3'd5;
        chr5  = 3'd4;
        @(posedge clk);
        #1 addr5 = 3'd7;
        @(posedge clk);
        #1 wr5 = 1'b0;
        @(posedge clk);
        #1;
        push("oor_hex5", 64'(c_HEX5_RST));
        chk(64'(hex5));
        wr5   = 1'b1;
        addr5 = 3'd4;
        @(posedge clk);
        #1 wr5 = 1'b0;
        @(posedge clk);
        #1;
        push("wr4_hex5", 64'(c_HEX5_WR));
        chk(64'(hex5));
        push("pos5", 64'd0);
        chk(64'(pos5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
